sfifo_param: RTL and testbench
==============================

// Module: sfifo_param
// PURPOSE
//   Single-clock parametrised FIFO; successor to the dual-clock FIFO.
//   Adds configurable depth/width, read mode (standard or first-word-fall-through),
//   programmable almost-full/almost-empty thresholds, fill count, synchronous flush
//   and sticky error flags. Used as the generic same-domain buffer between datapath stages.
// PARAMETERS
//   WIDTH      8    data width in bits (>=1)
//   DEPTH      16   entries; power of two, >=4
//   FWFT       0    0: standard read (rdata registered, valid 1 cycle after accepted rd_en);
//                   1: first-word-fall-through (rdata shows head entry whenever !empty)
//   AF_THRESH  12   almost_full asserted when count >= AF_THRESH (1..DEPTH-1)
//   AE_THRESH  4    almost_empty asserted when count <= AE_THRESH (1..DEPTH-1)
//   PTR_WIDTH  $clog2(DEPTH)  derived; do not override
// PORTS
//   clk           in   1            single clock, rising edge
//   res_n         in   1            asynchronous active-low reset
//   flush         in   1            synchronous clear of contents
//   wr_en         in   1            write request
//   wdata         in   WIDTH        write data
//   rd_en         in   1            read/pop request
//   rdata         out  WIDTH        read data
//   rvalid        out  1            rdata valid (standard: 1-cycle pulse; FWFT: = !empty)
//   empty         out  1            no entries
//   full          out  1            count == DEPTH
//   almost_empty  out  1            count <= AE_THRESH
//   almost_full   out  1            count >= AF_THRESH
//   count         out  PTR_WIDTH+1  current occupancy 0..DEPTH
//   overflow      out  1            1-cycle pulse: write rejected
//   underflow     out  1            1-cycle pulse: read rejected
//   err_sticky    out  2            {ovf_seen, unf_seen}; set by pulses, cleared by flush
// BEHAVIOUR
//   - Reset (res_n=0, async): pointers, count=0, empty=1, almost_empty=1, full=0,
//     almost_full=0, rdata=0, rvalid=0, overflow=0, underflow=0, err_sticky=0. Memory not reset.
//   - Pointers PTR_WIDTH+1 bits; wrap bit toggles on roll-over; address = low PTR_WIDTH bits.
//   - Accept rules per cycle (evaluated on state before the edge):
//       rd_ok = rd_en & !empty;  wr_ok = wr_en & (!full | rd_ok)
//     full with rd_en&wr_en: both accepted, count unchanged.
//     empty with rd_en&wr_en: write accepted, read rejected (underflow pulse),
//     also in FWFT mode (no same-cycle bypass).
//   - count next = count + wr_ok - rd_ok; all flags derived from registered count (glitch-free).
//   - overflow = registered (wr_en & !wr_ok); underflow = registered (rd_en & !rd_ok);
//     each high exactly the cycle after the offending request; the corresponding
//     err_sticky bit sets on that same edge.
//   - Standard mode: on rd_ok, rdata <= mem[rd_ptr], rvalid <= 1 next cycle; otherwise
//     rvalid <= 0, rdata holds last value.
//   - FWFT mode: rdata = mem[rd_ptr] combinationally; rvalid = !empty; rd_en pops head;
//     new head visible the cycle after the pop.
//   - Write data written at mem[wr_ptr] on wr_ok; visible to read no earlier than next cycle.
//   - flush: highest priority; next edge sets pointers/count = 0, clears err_sticky,
//     overflow, underflow, rvalid; concurrent wr_en/rd_en ignored (no error pulses).
//   - Reset mid-operation: immediate return to reset values; contents considered lost.
// STRUCTURE
//   - fifo_pkg: FIFO_MODE_STD/FIFO_MODE_FWFT constants, err_sticky bit indices.
//   - Sub-module fifo_mem_dp: WIDTH x DEPTH simple dual-port RAM, sync write,
//     async read port (registered externally in standard mode).
//   - Top holds pointers, count, flag logic and error registers.
// TESTING (WIDTH=8, DEPTH=16, AF=12, AE=4; run both FWFT=0 and 1)
//   1 Write 16 values 0x01..0x10 -> full=1 after 16th edge, almost_full from count 12,
//     count=16, no overflow.
//   2 From full, write 1 more -> overflow pulses 1 cycle, err_sticky[1]=1, count stays 16,
//     contents unchanged.
//   3 Read 16 -> data 0x01..0x10 in order (std: rvalid 1 cycle after rd_en),
//     empty=1, almost_empty from count 4; 17th read -> underflow pulse, err_sticky[0]=1.
//   4 Full + simultaneous wr_en/rd_en for 20 cycles -> count stays 16, no overflow,
//     order preserved across pointer wrap.
//   5 Empty + simultaneous wr_en/rd_en (0xAA) -> underflow pulse, count=1,
//     next read returns 0xAA.
//   6 count=7, flush with wr_en=1 -> count=0, empty=1, err_sticky=0; res_n low mid-burst
//     -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock parametrised FIFO.
package fifo_pkg;

    localparam bit FIFO_MODE_STD  = 1'b0;
    localparam bit FIFO_MODE_FWFT = 1'b1;

    localparam int unsigned ERR_UNF_BIT = 0;
    localparam int unsigned ERR_OVF_BIT = 1;
    localparam int unsigned ERR_WIDTH   = 2;

    // Field order matches the {ovf_seen, unf_seen} bit layout of err_sticky
    typedef struct packed {
        logic ovf_seen;
        logic unf_seen;
    } err_flags_t;

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_mem_dp #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/sfifo_param.sv
// Single-clock FIFO with standard or first-word-fall-through read, threshold
// flags, fill count, synchronous flush and sticky overflow/underflow flags.
module sfifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter bit          FWFT      = FIFO_MODE_STD,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 4,
    parameter int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rvalid,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic [ERR_WIDTH-1:0] err_sticky
);

    localparam int unsigned CW = PTR_WIDTH + 1;

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             empty_q,  empty_d;
    logic             full_q,   full_d;
    logic             ae_q,     ae_d;
    logic             af_q,     af_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q,  rdata_d;
    err_flags_t       err_q,    err_d;

    logic             rd_ok_c;
    logic             wr_ok_c;
    logic [WIDTH-1:0] mem_rdata_c;

    fifo_mem_dp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we      (wr_ok_c),
        .waddr   (wr_ptr_q[PTR_WIDTH-1:0]),
        .wdata   (wdata),
        .raddr   (rd_ptr_q[PTR_WIDTH-1:0]),
        .rdata_c (mem_rdata_c)
    );

    // Accept decisions, pointer/count update and next-state flags
    always_comb begin
        rd_ok_c  = rd_en & ~empty_q & ~flush;
        wr_ok_c  = wr_en & (~full_q | (rd_en & ~empty_q)) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = '0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
            if (rd_ok_c) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
                rvalid_d = 1'b1;
                rdata_d  = mem_rdata_c;
            end
            count_d = count_q + CW'(wr_ok_c) - CW'(rd_ok_c);
            ovf_d   = wr_en & ~wr_ok_c;
            unf_d   = rd_en & ~rd_ok_c;
            if (ovf_d) begin
                err_d.ovf_seen = 1'b1;
            end
            if (unf_d) begin
                err_d.unf_seen = 1'b1;
            end
        end

        // Flags come from the next count so they are registered alongside it
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        ae_d    = (count_d <= CW'(AE_THRESH));
        af_d    = (count_d >= CW'(AF_THRESH));
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // FWFT presents the head entry straight from the array
    assign rdata        = (FWFT == FIFO_MODE_FWFT) ? mem_rdata_c : rdata_q;
    assign rvalid       = (FWFT == FIFO_MODE_FWFT) ? ~empty_q : rvalid_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_sfifo_param.sv
// Scoreboard bench driving a standard and an FWFT instance in lockstep.
module tb_sfifo_param;

    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 4;

    logic       clk = 1'b0;
    logic       res_n;
    logic       flush;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;

    logic [7:0] s_rdata, f_rdata;
    logic       s_rvalid, f_rvalid;
    logic       s_empty, f_empty, s_full, f_full;
    logic       s_ae, f_ae, s_af, f_af;
    logic [4:0] s_count, f_count;
    logic       s_ovf, f_ovf, s_unf, f_unf;
    logic [1:0] s_err, f_err;

    int         n_pass  = 0;
    int         n_total = 0;
    int         mcount  = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    sfifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1'b0), .AF_THRESH(12), .AE_THRESH(4)) u_std (
        .clk(clk), .res_n(res_n), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(s_rdata), .rvalid(s_rvalid), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .err_sticky(s_err));

    sfifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1'b1), .AF_THRESH(12), .AE_THRESH(4)) u_fwft (
        .clk(clk), .res_n(res_n), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(f_rdata), .rvalid(f_rvalid), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .err_sticky(f_err));

    wire [3:0] s_flags = {s_empty, s_full, s_ae, s_af};
    wire [3:0] f_flags = {f_empty, f_full, f_ae, f_af};

    function automatic logic [3:0] exp_flags(input int c);
        return {c == 0, c == D, c <= AE, c >= AF};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        idle();
        wdata = 8'h00;
        repeat (2) @(negedge clk);
        n_total++; if (s_count !== 5'd0 || f_count !== 5'd0) $display("FAIL reset_count std=%0d fwft=%0d exp=0", s_count, f_count); else n_pass++;
        n_total++; if (s_flags !== 4'b1010 || f_flags !== 4'b1010) $display("FAIL reset_flags std=%b fwft=%b exp=1010", s_flags, f_flags); else n_pass++;
        n_total++; if ({s_rvalid, f_rvalid, s_ovf, f_ovf, s_unf, f_unf} !== 6'b0) $display("FAIL reset_pulses got=%b exp=000000", {s_rvalid, f_rvalid, s_ovf, f_ovf, s_unf, f_unf}); else n_pass++;
        n_total++; if (s_err !== 2'b00 || f_err !== 2'b00 || s_rdata !== 8'h00) $display("FAIL reset_err_rdata err=%b/%b rdata=%h exp=00/00/00", s_err, f_err, s_rdata); else n_pass++;
        res_n = 1'b1;
        tick();
    endtask

    task automatic fill_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wdata = 8'(base + i);
            q.push_back(wdata);
            mcount++;
            tick();
            n_total++; if (s_count !== 5'(mcount) || f_count !== 5'(mcount)) $display("FAIL fill_count std=%0d fwft=%0d exp=%0d", s_count, f_count, mcount); else n_pass++;
            n_total++; if (s_flags !== exp_flags(mcount) || f_flags !== exp_flags(mcount)) $display("FAIL fill_flags std=%b fwft=%b exp=%b", s_flags, f_flags, exp_flags(mcount)); else n_pass++;
            n_total++; if ({s_ovf, f_ovf} !== 2'b00) $display("FAIL fill_ovf got=%b exp=00", {s_ovf, f_ovf}); else n_pass++;
        end
        wr_en = 1'b0;
    endtask

    task automatic drain_n(input int n);
        logic [7:0] exp;
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            #1;
            n_total++; if (f_rvalid !== 1'b1 || f_rdata !== q[0]) $display("FAIL drain_fwft_head got=%h v=%b exp=%h v=1", f_rdata, f_rvalid, q[0]); else n_pass++;
            exp = q.pop_front();
            mcount--;
            tick();
            n_total++; if (s_rvalid !== 1'b1 || s_rdata !== exp) $display("FAIL drain_std_data got=%h v=%b exp=%h v=1", s_rdata, s_rvalid, exp); else n_pass++;
            n_total++; if (s_count !== 5'(mcount) || f_count !== 5'(mcount)) $display("FAIL drain_count std=%0d fwft=%0d exp=%0d", s_count, f_count, mcount); else n_pass++;
            n_total++; if (s_flags !== exp_flags(mcount) || f_flags !== exp_flags(mcount)) $display("FAIL drain_flags std=%b fwft=%b exp=%b", s_flags, f_flags, exp_flags(mcount)); else n_pass++;
            n_total++; if ({s_unf, f_unf} !== 2'b00) $display("FAIL drain_unf got=%b exp=00", {s_unf, f_unf}); else n_pass++;
        end
        rd_en = 1'b0;
        tick();
        n_total++; if (s_rvalid !== 1'b0) $display("FAIL drain_rvalid_end got=%b exp=0", s_rvalid); else n_pass++;
    endtask

    task automatic test_fill();
        fill_n(16, 1);
    endtask

    task automatic test_overflow();
        wr_en = 1'b1;
        wdata = 8'hEE;
        tick();
        wr_en = 1'b0;
        n_total++; if ({s_ovf, f_ovf} !== 2'b11) $display("FAIL ovf_pulse got=%b exp=11", {s_ovf, f_ovf}); else n_pass++;
        n_total++; if (s_err !== 2'b10 || f_err !== 2'b10) $display("FAIL ovf_sticky std=%b fwft=%b exp=10", s_err, f_err); else n_pass++;
        n_total++; if (s_count !== 5'd16 || f_count !== 5'd16) $display("FAIL ovf_count std=%0d fwft=%0d exp=16", s_count, f_count); else n_pass++;
        tick();
        n_total++; if ({s_ovf, f_ovf} !== 2'b00 || s_err !== 2'b10) $display("FAIL ovf_pulse_end ovf=%b err=%b exp=00/10", {s_ovf, f_ovf}, s_err); else n_pass++;
    endtask

    task automatic test_drain();
        drain_n(16);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_total++; if ({s_unf, f_unf} !== 2'b11) $display("FAIL unf_pulse got=%b exp=11", {s_unf, f_unf}); else n_pass++;
        n_total++; if (s_err !== 2'b11 || f_err !== 2'b11) $display("FAIL unf_sticky std=%b fwft=%b exp=11", s_err, f_err); else n_pass++;
        n_total++; if (s_rvalid !== 1'b0 || s_count !== 5'd0) $display("FAIL unf_state rvalid=%b count=%0d exp=0/0", s_rvalid, s_count); else n_pass++;
        tick();
        n_total++; if ({s_unf, f_unf} !== 2'b00) $display("FAIL unf_pulse_end got=%b exp=00", {s_unf, f_unf}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        fill_n(16, 8'h20);
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            wdata = 8'(8'h40 + i);
            #1;
            n_total++; if (f_rdata !== q[0]) $display("FAIL b2b_fwft_head got=%h exp=%h", f_rdata, q[0]); else n_pass++;
            exp = q.pop_front();
            q.push_back(wdata);
            tick();
            n_total++; if (s_rvalid !== 1'b1 || s_rdata !== exp) $display("FAIL b2b_std_data got=%h v=%b exp=%h v=1", s_rdata, s_rvalid, exp); else n_pass++;
            n_total++; if (s_count !== 5'd16 || f_count !== 5'd16) $display("FAIL b2b_count std=%0d fwft=%0d exp=16", s_count, f_count); else n_pass++;
            n_total++; if ({s_ovf, f_ovf, s_unf, f_unf} !== 4'b0) $display("FAIL b2b_err_pulse got=%b exp=0000", {s_ovf, f_ovf, s_unf, f_unf}); else n_pass++;
        end
        idle();
        drain_n(16);
    endtask

    task automatic test_empty_simul();
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hAA;
        #1;
        n_total++; if (f_rvalid !== 1'b0) $display("FAIL es_fwft_no_bypass got=%b exp=0", f_rvalid); else n_pass++;
        tick();
        idle();
        q.push_back(8'hAA);
        mcount = 1;
        n_total++; if ({s_unf, f_unf} !== 2'b11) $display("FAIL es_unf got=%b exp=11", {s_unf, f_unf}); else n_pass++;
        n_total++; if (s_count !== 5'd1 || f_count !== 5'd1 || s_rvalid !== 1'b0) $display("FAIL es_count std=%0d fwft=%0d rv=%b exp=1/1/0", s_count, f_count, s_rvalid); else n_pass++;
        tick();
        drain_n(1);
    endtask

    task automatic test_flush_reset();
        fill_n(7, 8'h60);
        n_total++; if (s_err !== 2'b11) $display("FAIL pre_flush_err got=%b exp=11", s_err); else n_pass++;
        flush = 1'b1;
        wr_en = 1'b1;
        wdata = 8'h77;
        tick();
        idle();
        q.delete();
        mcount = 0;
        n_total++; if (s_count !== 5'd0 || f_count !== 5'd0) $display("FAIL flush_count std=%0d fwft=%0d exp=0", s_count, f_count); else n_pass++;
        n_total++; if (s_flags !== 4'b1010 || f_flags !== 4'b1010) $display("FAIL flush_flags std=%b fwft=%b exp=1010", s_flags, f_flags); else n_pass++;
        n_total++; if (s_err !== 2'b00 || f_err !== 2'b00) $display("FAIL flush_err std=%b fwft=%b exp=00", s_err, f_err); else n_pass++;
        n_total++; if ({s_rvalid, f_rvalid, s_ovf, f_ovf, s_unf, f_unf} !== 6'b0) $display("FAIL flush_pulses got=%b exp=000000", {s_rvalid, f_rvalid, s_ovf, f_ovf, s_unf, f_unf}); else n_pass++;
        tick();
        n_total++; if (s_count !== 5'd0) $display("FAIL flush_write_ignored got=%0d exp=0", s_count); else n_pass++;

        // Reset in the middle of a write burst
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wdata = 8'(8'h80 + i);
            tick();
        end
        #2 res_n = 1'b0;
        #1;
        n_total++; if (s_count !== 5'd0 || f_count !== 5'd0) $display("FAIL rst_mid_count std=%0d fwft=%0d exp=0", s_count, f_count); else n_pass++;
        n_total++; if (s_flags !== 4'b1010 || f_flags !== 4'b1010) $display("FAIL rst_mid_flags std=%b fwft=%b exp=1010", s_flags, f_flags); else n_pass++;
        n_total++; if (s_rdata !== 8'h00 || s_rvalid !== 1'b0 || f_rvalid !== 1'b0) $display("FAIL rst_mid_rdata got=%h v=%b/%b exp=00 v=0/0", s_rdata, s_rvalid, f_rvalid); else n_pass++;
        idle();
        @(negedge clk);
        res_n = 1'b1;
        tick();
        fill_n(2, 8'h90);
        drain_n(2);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_empty_simul();
        test_flush_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
